// File: rtl/mem_bus_responder_if.sv
// Byte-serial memory bus between the CPU memory controller (master) and the
// memory/IO responder (slave). Read data and the CPU enable flow back to the master.
interface mem_bus_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        rdy;

  modport master (
    output mem_a,
    output mem_wr,
    output mem_dout,
    input  mem_din,
    input  rdy
  );

  modport slave (
    input  mem_a,
    input  mem_wr,
    input  mem_dout,
    output mem_din,
    output rdy
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-bus responder: byte RAM, TX FIFO behind a data port, one-byte RX holding
// register and a status port. rdy stalls the CPU while the TX FIFO is full.
module mem_bus_responder #(
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] IO_ADDR    = 32'h0003_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mem_bus_responder_if.slave      bus,
  output logic [7:0]              io_tx_data_o,
  output logic                    io_tx_valid_o,
  input  logic                    io_tx_ready_i,
  input  logic [7:0]              io_rx_data_i,
  input  logic                    io_rx_valid_i,
  output logic                    io_rx_ready_o
);

  localparam int             PTR_W     = $clog2(FIFO_DEPTH);
  localparam int             RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [31:0]    STAT_ADDR = IO_ADDR + 32'd4;
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  // Storage (never reset)
  logic [7:0] ram_q  [RAM_DEPTH];
  logic [7:0] fifo_q [FIFO_DEPTH];

  // Control state
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_full_q, rx_full_d;
  logic [7:0]       mem_din_q;

  // Decode and handshake terms
  logic                  sel_data;
  logic                  sel_stat;
  logic                  sel_ram;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  tx_full;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  ram_we;
  logic                  ram_re;
  logic                  data_rd;
  logic                  stat_rd;
  logic                  rx_clear;
  logic                  rx_capture;

  always_comb begin
    sel_data   = (bus.mem_a == IO_ADDR);
    sel_stat   = (bus.mem_a == STAT_ADDR);
    sel_ram    = !sel_data && !sel_stat;
    ram_idx    = bus.mem_a[ADDR_WIDTH-1:0];
    tx_full    = (count_q == FULL_CNT);
    accept     = !tx_full;
    push       = accept &&  bus.mem_wr && sel_data;
    pop        = (count_q != '0) && io_tx_ready_i;
    ram_we     = accept &&  bus.mem_wr && sel_ram;
    ram_re     = accept && !bus.mem_wr && sel_ram;
    data_rd    = accept && !bus.mem_wr && sel_data;
    stat_rd    = accept && !bus.mem_wr && sel_stat;
    rx_clear   = data_rd && rx_full_q;
    rx_capture = io_rx_valid_i && !rx_full_q;
  end

  // FIFO pointer/count next state; a same-edge push and pop leave count unchanged
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Clear only empties a full register and capture only fills an empty one,
  // so the two never act on the same edge.
  always_comb begin
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    if (rx_capture) begin
      rx_full_d = 1'b1;
      rx_data_d = io_rx_data_i;
    end else if (rx_clear) begin
      rx_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[ram_idx] <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rx_full_q <= 1'b0;
      rx_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rx_full_q <= rx_full_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Read data register: holds across writes and stalled edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din_q <= 8'h00;
    end else if (ram_re) begin
      mem_din_q <= ram_q[ram_idx];
    end else if (data_rd) begin
      mem_din_q <= rx_full_q ? rx_data_q : 8'h00;
    end else if (stat_rd) begin
      mem_din_q <= {6'b0, tx_full, rx_full_q};
    end
  end

  assign bus.mem_din    = mem_din_q;
  assign bus.rdy        = accept;
  assign io_tx_valid_o  = (count_q != '0);
  assign io_tx_data_o   = fifo_q[rd_ptr_q];
  assign io_rx_ready_o  = !rx_full_q;

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Responder end of the byte-serial memory bus driven by the CPU memory controller. It provides three things:
- a byte-wide synchronous RAM;
- a memory-mapped output port backed by a small TX FIFO;
- a one-byte RX holding register.

It drives `rdy` to stall the CPU while the TX FIFO is full. It sits at the top level between the CPU's `mem_a`/`mem_wr`/`mem_dout`/`mem_din` pins and the host I/O link.

## Interface
Parameters:
- `ADDR_WIDTH`, 17: RAM depth is 2^ADDR_WIDTH bytes. RAM accesses use `mem_a[ADDR_WIDTH-1:0]`; higher bits are ignored, so addresses wrap.
- `IO_ADDR`, 32'h0003_0000: data port address. `IO_ADDR+4` is the status port.
- `FIFO_DEPTH`, 8: TX FIFO entries. Must be a power of two, at least 2.

Ports (reset is asynchronous and active-low):
- `clk`  in  1: single clock; everything changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mem_a`  in  32: byte address from the controller.
- `mem_wr`  in  1: 1 means write, 0 means read.
- `mem_dout`  in  8: write data from the controller.
- `mem_din`  out  8: registered read data to the controller.
- `rdy`  out  1: CPU enable. Low stalls the CPU and the bus.
- `io_tx_data`  out  8: head byte of the TX FIFO.
- `io_tx_valid`  out  1: TX FIFO is non-empty.
- `io_tx_ready`  in  1: host accepts `io_tx_data`.
- `io_rx_data`  in  8: byte from the host.
- `io_rx_valid`  in  1: `io_rx_data` is valid.
- `io_rx_ready`  out  1: RX holding register is empty.

## Operation
- **Accepted cycle:** any rising edge with `rdy`=1. Bus inputs on edges with `rdy`=0 are ignored and cause no side effects.
- **Address decode:**
  - `mem_a == IO_ADDR`: data port.
  - `mem_a == IO_ADDR+4`: status port.
  - Anything else: RAM.
- **RAM read:** `mem_din <= ram[mem_a[ADDR_WIDTH-1:0]]`.
- **RAM write:** `ram[...] <= mem_dout`. `mem_din` holds its previous value.
- **Data port write:** push `mem_dout` into the TX FIFO.
- **Data port read:**
  - If the RX register is full: `mem_din <=` RX byte, and the RX register is cleared.
  - If empty: `mem_din <= 8'h00`.
- **Status port read:** `mem_din <= {6'b0, tx_full, rx_full}`. Writes to the status port are ignored.
- **TX FIFO:**
  - Circular buffer with log2(FIFO_DEPTH)-bit read and write pointers that wrap naturally.
  - Count register is log2(FIFO_DEPTH)+1 bits wide.
  - `io_tx_valid = (count != 0)`.
  - `io_tx_data = fifo[rd_ptr]`.
  - A pop happens on an edge where `io_tx_valid && io_tx_ready`. Pops are independent of `rdy`.
  - Push and pop on the same edge: count unchanged, both pointers advance.
- **Stall:** `rdy = (count != FIFO_DEPTH)`, decoded combinationally from the count register. A full FIFO therefore never receives a push.
- **RX register:**
  - `io_rx_ready = !rx_full`.
  - Captures `io_rx_data` on an edge where `io_rx_valid && io_rx_ready`.
  - A data-port read and a capture can never coincide on the same byte: a read only clears a full register, and a capture only fills an empty one. Once cleared, the next capture may happen on the following edge.
- **Reset (`rst_n` low), effective immediately and mid-operation:**
  - `mem_din` = 0.
  - TX FIFO emptied, so `io_tx_valid` = 0 and `rdy` = 1.
  - RX register cleared, so `io_rx_ready` = 1.
  - `io_tx_data` is don't-care.
  - RAM contents are not reset and keep their values.

## Timing
- Read latency is one cycle. The address is presented in cycle N and sampled at the end of N; `mem_din` is valid throughout N+1. This matches the controller, which presents the next address while capturing the current byte.
- Back-to-back reads with a new address every cycle sustain one byte per cycle.
- Write: committed at the accepting edge. A read of the same address on the next cycle returns the new byte.
- TX push at edge E: `io_tx_valid` rises after E. The earliest pop is at edge E+1.
- A push that fills the FIFO at edge E drives `rdy` low after E. `rdy` returns high the cycle after the first pop.
- RX capture at edge E: the byte is readable via a data-port read accepted at edge E+1 or later.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-stream with the FIFO holding 3 bytes → `mem_din`=0, `io_tx_valid`=0, `rdy`=1, `io_rx_ready`=1. RAM byte at 0x100 still reads its prior value after reset.
- **RAM path:**
  - Write 0xA5 to 0x00123, then read 0x00123 on the next cycle → `mem_din`=0xA5 one cycle after the read.
  - Write 0x5A to 0x20123 → it aliases to 0x00123 (wrap) and reads back 0x5A.
- **TX backpressure:**
  - Hold `io_tx_ready`=0 and write 8 bytes 0x01..0x08 to 0x30000 → `rdy` goes low after the 8th push, and a 9th write held during the stall is not pushed.
  - Raise `io_tx_ready` → bytes drain 0x01..0x08 in order, one per cycle, and `rdy` returns high one cycle after the first pop.
- **Simultaneous push/pop:** with 4 entries queued, push 0x77 while popping every cycle → count stays 4 and 0x77 emerges 4 pops later.
- **RX path:**
  - Host sends 0x41 → `io_rx_ready` drops. Status read at 0x30004 returns 0x01. Data read at 0x30000 returns 0x41 and `io_rx_ready` rises.
  - A second data read with the register empty returns 0x00.
- **Status when full:** with the FIFO full and an RX byte pending → after a pop restores `rdy`, a status read accepted before the next push returns 0x01 (tx_full=0, rx_full=1). With the FIFO full and no RX byte, a status read cannot be issued: `rdy`=0 stalls the bus.
